// File: rtl/vu_level_if.sv
// Sample-strobe / meter-level bundle between the I2S front end and the VU PWM stage.
// Peak outputs exist only when VU_PEAK_HOLD_EN is defined.
interface vu_level_if;
    logic       l_data_en;
    logic       r_data_en;
    logic [7:0] l_audio_signal;
    logic [7:0] r_audio_signal;
    logic       audio_enable;
    logic [6:0] l_level;
    logic [6:0] r_level;
    logic       l_level_valid;
    logic       r_level_valid;
    logic       overrun;
`ifdef VU_PEAK_HOLD_EN
    logic [6:0] l_peak;
    logic [6:0] r_peak;

    modport master (
        output l_data_en, r_data_en, l_audio_signal, r_audio_signal, audio_enable,
        input  l_level, r_level, l_level_valid, r_level_valid, overrun, l_peak, r_peak
    );
    modport slave (
        input  l_data_en, r_data_en, l_audio_signal, r_audio_signal, audio_enable,
        output l_level, r_level, l_level_valid, r_level_valid, overrun, l_peak, r_peak
    );
`else
    modport master (
        output l_data_en, r_data_en, l_audio_signal, r_audio_signal, audio_enable,
        input  l_level, r_level, l_level_valid, r_level_valid, overrun
    );
    modport slave (
        input  l_data_en, r_data_en, l_audio_signal, r_audio_signal, audio_enable,
        output l_level, r_level, l_level_valid, r_level_valid, overrun
    );
`endif
endinterface

// File: rtl/vu_level_sequencer.sv
// Stereo VU level sequencer: one shared rectifying accumulator and ballistics unit, time-shared L/R.
// Optional peak-hold per channel is enabled with the VU_PEAK_HOLD_EN macro.
module vu_level_sequencer #(
    parameter int AVG_LOG2      = 4,
    parameter int ATTACK_SHIFT  = 1,
    parameter int RELEASE_SHIFT = 4
) (
    input  logic      clk,
    input  logic      reset_n,
    vu_level_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_BALLIST = 2'd2,
        S_PUBLISH = 2'd3
    } state_t;

    localparam logic [4:0] CNT_LAST = 5'((1 << AVG_LOG2) - 1);

    state_t     state_q, state_d;
    logic       ch_sel_q, ch_sel_d;
    logic [6:0] mag_q, mag_d;
    logic       en_prev_q;
    logic       overrun_q, overrun_d;

    logic       en;
    logic       enable_rise;
    logic [1:0] strobe;
    logic [7:0] sample_in [2];
    logic [1:0] pend_vec;
    logic [7:0] samp_arr  [2];
    logic [11:0] acc_arr  [2];
    logic [4:0] cnt_arr   [2];
    logic [6:0] level_arr [2];
    logic [1:0] valid_vec;
    logic [1:0] ovr_set;
    logic       grant;
    logic       grant_ch;
    logic [6:0] new_level;
    logic [11:0] acc_sel;
    logic [6:0] avg;
    logic [6:0] lvl;
    logic [6:0] diff;
    logic [6:0] step;

    assign en           = bus.audio_enable;
    assign enable_rise  = en & ~en_prev_q;
    assign strobe       = {bus.r_data_en, bus.l_data_en};
    assign sample_in[0] = bus.l_audio_signal;
    assign sample_in[1] = bus.r_audio_signal;

    // -128 has no positive 8-bit counterpart, so it saturates to full scale.
    function automatic logic [6:0] rectify(input logic [7:0] s);
        logic [7:0] neg;
        neg = 8'd0 - s;
        if (s == 8'h80)
            return 7'd127;
        else if (s[7])
            return neg[6:0];
        else
            return s[6:0];
    endfunction

    always_comb begin
        grant    = 1'b0;
        grant_ch = 1'b0;
        if (state_q == S_IDLE && en) begin
            if (pend_vec[0]) begin
                grant    = 1'b1;
                grant_ch = 1'b0;
            end else if (pend_vec[1]) begin
                grant    = 1'b1;
                grant_ch = 1'b1;
            end
        end
    end

    // Ballistics: step never exceeds the distance to avg, so the level stays in 0..127.
    always_comb begin
        acc_sel   = acc_arr[ch_sel_q];
        avg       = 7'(acc_sel >> AVG_LOG2);
        lvl       = level_arr[ch_sel_q];
        diff      = 7'd0;
        step      = 7'd0;
        new_level = lvl;
        if (avg > lvl) begin
            diff = avg - lvl;
            step = diff >> ATTACK_SHIFT;
            if (step == 7'd0) step = 7'd1;
            new_level = lvl + step;
        end else if (avg < lvl) begin
            diff = lvl - avg;
            step = diff >> RELEASE_SHIFT;
            if (step == 7'd0) step = 7'd1;
            new_level = lvl - step;
        end
    end

    always_comb begin
        state_d  = state_q;
        ch_sel_d = ch_sel_q;
        mag_d    = mag_q;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    state_d  = S_ACCUM;
                    ch_sel_d = grant_ch;
                    mag_d    = rectify(samp_arr[grant_ch]);
                end
            end
            S_ACCUM: begin
                if (!en)
                    state_d = S_IDLE;
                else if (cnt_arr[ch_sel_q] == CNT_LAST)
                    state_d = S_BALLIST;
                else
                    state_d = S_IDLE;
            end
            S_BALLIST: state_d = en ? S_PUBLISH : S_IDLE;
            S_PUBLISH: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        overrun_d = overrun_q | (|ovr_set);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ch_sel_q  <= 1'b0;
            mag_q     <= 7'd0;
            en_prev_q <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_sel_q  <= ch_sel_d;
            mag_q     <= mag_d;
            en_prev_q <= en;
            overrun_q <= overrun_d;
        end
    end

`ifdef VU_PEAK_HOLD_EN
    localparam logic [9:0] HOLD_WINDOWS = 10'd600;
    logic [6:0] peak_arr [2];
`endif

    for (genvar gi = 0; gi < 2; gi++) begin : gen_ch
        logic        pend_q, pend_d;
        logic [7:0]  samp_q, samp_d;
        logic [11:0] acc_q, acc_d;
        logic [4:0]  cnt_q, cnt_d;
        logic [6:0]  level_q, level_d;
        logic        valid_q, valid_d;
        logic        granted;
        logic        selected;
        logic        ovr;

        assign granted  = grant && (grant_ch == 1'(gi));
        assign selected = (ch_sel_q == 1'(gi));

        // A strobe coinciding with its own grant is a fresh sample, not an overrun.
        always_comb begin
            pend_d = pend_q;
            samp_d = samp_q;
            ovr    = 1'b0;
            if (!en) begin
                pend_d = 1'b0;
            end else begin
                if (granted) pend_d = 1'b0;
                if (strobe[gi]) begin
                    samp_d = sample_in[gi];
                    pend_d = 1'b1;
                    ovr    = pend_q & ~granted;
                end
            end

            acc_d = acc_q;
            cnt_d = cnt_q;
            if (!en) begin
                acc_d = 12'd0;
                cnt_d = 5'd0;
            end else if (state_q == S_ACCUM && selected) begin
                acc_d = acc_q + {5'd0, mag_q};
                cnt_d = (cnt_q == CNT_LAST) ? 5'd0 : cnt_q + 5'd1;
            end else if (state_q == S_BALLIST && selected) begin
                acc_d = 12'd0;
                cnt_d = 5'd0;
            end

            level_d = level_q;
            valid_d = 1'b0;
            if (enable_rise) begin
                level_d = 7'd0;
                valid_d = 1'b1;
            end else if (en && state_q == S_BALLIST && selected) begin
                level_d = new_level;
                valid_d = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                pend_q  <= 1'b0;
                samp_q  <= 8'd0;
                acc_q   <= 12'd0;
                cnt_q   <= 5'd0;
                level_q <= 7'd0;
                valid_q <= 1'b0;
            end else begin
                pend_q  <= pend_d;
                samp_q  <= samp_d;
                acc_q   <= acc_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                valid_q <= valid_d;
            end
        end

        assign pend_vec[gi]  = pend_q;
        assign samp_arr[gi]  = samp_q;
        assign acc_arr[gi]   = acc_q;
        assign cnt_arr[gi]   = cnt_q;
        assign level_arr[gi] = level_q;
        assign valid_vec[gi] = valid_q;
        assign ovr_set[gi]   = ovr;

`ifdef VU_PEAK_HOLD_EN
        logic [6:0] peak_q, peak_d;
        logic [9:0] hold_q, hold_d;

        // Level is already settled during PUBLISH, so it is the value compared here.
        always_comb begin
            peak_d = peak_q;
            hold_d = hold_q;
            if (state_q == S_PUBLISH && selected) begin
                if (level_q >= peak_q) begin
                    peak_d = level_q;
                    hold_d = HOLD_WINDOWS;
                end else if (hold_q != 10'd0) begin
                    hold_d = hold_q - 10'd1;
                end else if (peak_q != 7'd0) begin
                    peak_d = peak_q - 7'd1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                peak_q <= 7'd0;
                hold_q <= 10'd0;
            end else begin
                peak_q <= peak_d;
                hold_q <= hold_d;
            end
        end

        assign peak_arr[gi] = peak_q;
`endif
    end

    assign bus.l_level       = level_arr[0];
    assign bus.r_level       = level_arr[1];
    assign bus.l_level_valid = valid_vec[0];
    assign bus.r_level_valid = valid_vec[1];
    assign bus.overrun       = overrun_q;
`ifdef VU_PEAK_HOLD_EN
    assign bus.l_peak        = peak_arr[0];
    assign bus.r_peak        = peak_arr[1];
`endif
endmodule
